ex_mdu_ctrl: RTL

Iterative multiply/divide sequencer in the EX stage, beside the single-cycle ALU. Accepts one MDU operation from the ID/EX operand signals and runs it over WIDTH cycles on one shared add/subtract datapath. Holds the pipeline with a stall request until the result is ready; EX muxes the result into ex_reg in the done cycle.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_addsub.sv | 14 +
 rtl/ex_mdu_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings and constants for the ex_mdu_ctrl multiply/divide sequencer (S_FIX exists only when MDU_SIGNED_EN is defined)
package mdu_pkg;
  localparam int MDU_OP_W = 3;
  localparam logic DIV0_Q_FILL = 1'b1;
  typedef enum logic [MDU_OP_W-1:0] {
    OP_MUL   = 3'b000,
    OP_MULH  = 3'b001,
    OP_MULHU = 3'b010,
    OP_RSV   = 3'b011,
    OP_DIV   = 3'b100,
    OP_DIVU  = 3'b101,
    OP_REM   = 3'b110,
    OP_REMU  = 3'b111
  } mdu_op_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
`ifdef MDU_SIGNED_EN
    S_FIX,
`endif
    S_DONE
  } mdu_state_t;
endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: W-bit add/subtract (a, b, sub in; y sum/difference, co carry-out or not-borrow out), shared by multiply and divide
module mdu_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         co
);
  logic [W-1:0] bx;
  assign bx = sub ? ~b : b;
  assign {co, y} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
endmodule

// File: rtl/ex_mdu_ctrl.sv
// ex_mdu_ctrl: iterative EX-stage mul/div sequencer; in clk, rst (async active-low), start, op, in_0, in_1, flush; out busy, stall_req, done, result, div_by_zero; MDU_SIGNED_EN adds signed MULH/DIV/REM via FIX state
module ex_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    in_0,
  input  logic [WIDTH-1:0]    in_1,
  input  logic                flush,
  output logic                busy,
  output logic                stall_req,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                div_by_zero
);
  mdu_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [MDU_OP_W-1:0] op_r;
  logic [WIDTH-1:0] hi, lo, b_r, res_r, res_n, hi_n, lo_n, hi_m, lo_m, hi_d, lo_d, a0, a1, sel;
  logic [WIDTH:0] add_a, add_b, add_y;
  logic add_sub, add_co, dbz_r, dbz_n, accept, in_fix;
`ifdef MDU_SIGNED_EN
  logic sgn_op, s0, s1, sgn_r, neg_r;
  logic [WIDTH-1:0] fix_v;
  assign sgn_op = op == OP_MULH || op == OP_DIV || op == OP_REM;
  assign s0 = sgn_op & in_0[WIDTH-1];
  assign s1 = sgn_op & in_1[WIDTH-1];
  assign a0 = s0 ? -in_0 : in_0;
  assign a1 = s1 ? -in_1 : in_1;
  assign in_fix = state == S_FIX;
  assign fix_v = op_r[2] ? (op_r[1] ? hi : lo) : hi;
  // negation is ~v + 1; for MULH the whole product is negated, so the +1 reaches hi only when lo is zero
  assign add_a = in_fix ? {1'b0, ~fix_v} : state == S_DIV ? {hi, lo[WIDTH-1]} : {1'b0, hi};
  assign add_b = in_fix ? {{WIDTH{1'b0}}, op_r[2] | ~|lo} : {1'b0, b_r};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn_r <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      sgn_r <= sgn_op;
      neg_r <= op == OP_REM ? s0 : s0 ^ s1;
    end
  end
`else
  assign a0 = in_0;
  assign a1 = in_1;
  assign in_fix = 1'b0;
  assign add_a = state == S_DIV ? {hi, lo[WIDTH-1]} : {1'b0, hi};
  assign add_b = {1'b0, b_r};
`endif
  assign add_sub = state == S_DIV;
  mdu_addsub #(.W(WIDTH + 1)) u_addsub (
    .a  (add_a),
    .b  (add_b),
    .sub(add_sub),
    .y  (add_y),
    .co (add_co)
  );
  assign hi_m = lo[0] ? add_y[WIDTH:1] : {1'b0, hi[WIDTH-1:1]};
  assign lo_m = {lo[0] ? add_y[0] : hi[0], lo[WIDTH-1:1]};
  assign hi_d = add_co ? add_y[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign lo_d = {lo[WIDTH-2:0], add_co};
  assign hi_n = state == S_DIV ? hi_d : hi_m;
  assign lo_n = state == S_DIV ? lo_d : lo_m;
  assign sel = op_r[2] ? (op_r[1] ? hi_n : lo_n) : (op_r[1:0] == 2'b00 ? lo_n : hi_n);
  assign accept = state == S_IDLE && start && !flush;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign result = res_r;
  assign div_by_zero = dbz_r;
  assign stall_req = !flush && (accept || state == S_MUL || state == S_DIV || in_fix);
  always_comb begin
    state_n = state;
    res_n = '0;
    dbz_n = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (op == OP_RSV) state_n = S_DONE;
        else if (op[2] && in_1 == '0) begin
          state_n = S_DONE;
          res_n = op[1] ? in_0 : {WIDTH{DIV0_Q_FILL}};
          dbz_n = 1'b1;
        end else state_n = op[2] ? S_DIV : S_MUL;
      end
      S_MUL, S_DIV: if (cnt == '0) begin
        res_n = sel;
`ifdef MDU_SIGNED_EN
        state_n = sgn_r ? S_FIX : S_DONE;
`else
        state_n = S_DONE;
`endif
      end
`ifdef MDU_SIGNED_EN
      S_FIX: begin
        state_n = S_DONE;
        res_n = neg_r ? add_y[WIDTH-1:0] : fix_v;
      end
`endif
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n = S_IDLE;
      res_n = '0;
      dbz_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      op_r <= '0;
      hi <= '0;
      lo <= '0;
      b_r <= '0;
      res_r <= '0;
      dbz_r <= 1'b0;
    end else begin
      state <= state_n;
      res_r <= res_n;
      dbz_r <= dbz_n;
      if (accept) begin
        op_r <= op;
        cnt <= CNT_W'(WIDTH - 1);
        hi <= '0;
        lo <= op[2] ? a0 : a1;
        b_r <= op[2] ? a1 : a0;
      end else if (state == S_MUL || state == S_DIV) begin
        hi <= hi_n;
        lo <= lo_n;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule
